// File: rtl/mp_ram_pkg.sv
// Shared constants and types for the multi-port word memory.
// Word/address widths match the RISC-V core's 32-bit buses.
package mp_ram_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned MEM_BE_WIDTH = 4;

    typedef enum logic [1:0] {
        LAT_ONE = 2'd1,
        LAT_TWO = 2'd2
    } latency_e;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [WORD_WIDTH-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/mp_ram_rsp_stage.sv
// One response register stage: valid pulses for a single cycle, rdata/err
// are captured only with a valid response and hold their value otherwise.
module mp_ram_rsp_stage
    import mp_ram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  rsp_t next_rsp,
    output rsp_t rsp
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp <= '0;
        end else begin
            rsp.valid <= next_rsp.valid;
            if (next_rsp.valid) begin
                rsp.err   <= next_rsp.err;
                rsp.rdata <= next_rsp.rdata;
            end
        end
    end

endmodule

// File: rtl/mp_ram.sv
// Parametrised multi-port word memory with byte-masked writes, per-port
// write permission, out-of-range flagging and 1- or 2-cycle response latency.
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int unsigned           NUM_PORTS     = 2,
    parameter int unsigned           SIZE_BYTES    = 2048,
    parameter int unsigned           LATENCY       = 1,
    parameter logic [NUM_PORTS-1:0]  WRITE_MASK    = '0,
    parameter                        INIT_FILE_BIN = ""
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_valid_i,
    input  logic [NUM_PORTS-1:0]             req_we_i,
    input  logic [MEM_BE_WIDTH*NUM_PORTS-1:0] req_be_i,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  req_addr_i,
    input  logic [WORD_WIDTH*NUM_PORTS-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]             rsp_valid_o,
    output logic [WORD_WIDTH*NUM_PORTS-1:0]  rsp_rdata_o,
    output logic [NUM_PORTS-1:0]             rsp_err_o
);

    localparam int unsigned DEPTH = SIZE_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]     idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_err;
    logic [NUM_PORTS-1:0] do_write;
    rsp_t                 issue_rsp [NUM_PORTS];
    logic                 unused_addr_lsbs;

    // Request decode and read sampling; rdata is the pre-write word.
    always_comb begin
        unused_addr_lsbs = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            idx[p]     = req_addr_i[p*ADDR_WIDTH+2 +: IDX_W];
            req_err[p] = (req_addr_i[p*ADDR_WIDTH+IDX_W+2 +: ADDR_WIDTH-IDX_W-2] != '0)
                       || (req_we_i[p] && !WRITE_MASK[p]);
            do_write[p] = rst_n && req_valid_i[p] && req_we_i[p] && !req_err[p];

            issue_rsp[p].valid = req_valid_i[p];
            issue_rsp[p].err   = req_valid_i[p] && req_err[p];
            issue_rsp[p].rdata = (req_valid_i[p] && !req_err[p]) ? mem[idx[p]] : '0;

            unused_addr_lsbs = unused_addr_lsbs ^ (^req_addr_i[p*ADDR_WIDTH +: 2]);
        end
    end

    logic [IDX_W-1:0]      bd_idx;
    logic [WORD_WIDTH-1:0] bd_data;
    logic                  bd_seq;
    logic                  bd_ack;

    function automatic logic [WORD_WIDTH-1:0] readWord(input int unsigned byte_addr);
        return mem[IDX_W'(byte_addr >> 2)];
    endfunction

    // Backdoor writes are posted and land on the next rising edge.
    function automatic void writeWord(input int unsigned byte_addr,
                                      input logic [WORD_WIDTH-1:0] data);
        bd_idx  = IDX_W'(byte_addr >> 2);
        bd_data = data;
        bd_seq  = !bd_seq;
    endfunction

    // Later ports overwrite earlier ones lane by lane, so the highest port wins.
    always_ff @(posedge clk) begin
        bd_ack <= bd_seq;
        if (bd_seq != bd_ack) begin
            mem[bd_idx] <= bd_data;
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned b = 0; b < MEM_BE_WIDTH; b++) begin
                if (do_write[p] && req_be_i[p*MEM_BE_WIDTH+b]) begin
                    mem[idx[p]][8*b +: 8] <= req_wdata_i[p*WORD_WIDTH+8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rsp_t s1_rsp;

        mp_ram_rsp_stage u_stage1 (
            .clk      (clk),
            .rst_n    (rst_n),
            .next_rsp (issue_rsp[p]),
            .rsp      (s1_rsp)
        );

        if (LATENCY == int'(LAT_TWO)) begin : g_lat2
            rsp_t s2_rsp;

            mp_ram_rsp_stage u_stage2 (
                .clk      (clk),
                .rst_n    (rst_n),
                .next_rsp (s1_rsp),
                .rsp      (s2_rsp)
            );

            assign rsp_valid_o[p]                      = s2_rsp.valid;
            assign rsp_err_o[p]                        = s2_rsp.err;
            assign rsp_rdata_o[p*WORD_WIDTH +: WORD_WIDTH] = s2_rsp.rdata;
        end else begin : g_lat1
            assign rsp_valid_o[p]                      = s1_rsp.valid;
            assign rsp_err_o[p]                        = s1_rsp.err;
            assign rsp_rdata_o[p*WORD_WIDTH +: WORD_WIDTH] = s1_rsp.rdata;
        end
    end

endmodule

// File: tb/tb_mp_ram.sv
// Bench for mp_ram: a 3-port LATENCY=1 instance and a 2-port LATENCY=2
// instance driven in lockstep and checked against an array-based model.
module tb_mp_ram;

    localparam int unsigned DEPTH = 512;

    typedef struct packed {
        logic         strict;
        logic [3:0]   v;
        logic [3:0]   e;
        logic [3:0]   k;
        logic [127:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [2:0]  a_valid, a_we, a_rv, a_re;
    logic [11:0] a_be;
    logic [95:0] a_addr, a_wdata, a_rd;

    logic [1:0]  b_valid, b_we, b_rv, b_re;
    logic [7:0]  b_be;
    logic [63:0] b_addr, b_wdata, b_rd;

    logic [31:0] mm [2][DEPTH];
    bit          kn [2][DEPTH];
    logic [31:0] pre [16];
    exp_t        qa[$];
    exp_t        qb[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mp_ram #(
        .NUM_PORTS(3), .SIZE_BYTES(2048), .LATENCY(1),
        .WRITE_MASK(3'b011), .INIT_FILE_BIN("")
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(a_valid), .req_we_i(a_we), .req_be_i(a_be),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rv), .rsp_rdata_o(a_rd), .rsp_err_o(a_re)
    );

    mp_ram #(
        .NUM_PORTS(2), .SIZE_BYTES(2048), .LATENCY(2),
        .WRITE_MASK(2'b10), .INIT_FILE_BIN("")
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_valid), .req_we_i(b_we), .req_be_i(b_be),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rv), .rsp_rdata_o(b_rd), .rsp_err_o(b_re)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a plain word array; reads see values before this
    // cycle's writes, and writes are applied in port order so higher ports win.
    task automatic model(input int unsigned d, input int unsigned np, input logic [3:0] mask,
                         input logic [3:0] valid, input logic [3:0] we, input logic [15:0] be,
                         input logic [127:0] addr, input logic [127:0] wdata, output exp_t r);
        logic [31:0] a;
        bit          bad [4];
        int unsigned wi  [4];
        r = '0;
        if (!rst_n) begin
            r.strict = 1'b1;
        end else begin
            for (int unsigned p = 0; p < np; p++) begin
                bad[p] = 1'b0;
                wi[p]  = 0;
                if (valid[p]) begin
                    a      = addr[32*p +: 32];
                    bad[p] = (a >= 32'd2048) || (we[p] && !mask[p]);
                    wi[p]  = a / 4;
                    r.v[p] = 1'b1;
                    r.e[p] = bad[p];
                    r.k[p] = bad[p] || kn[d][wi[p]];
                    r.d[32*p +: 32] = bad[p] ? 32'h0 : mm[d][wi[p]];
                end
            end
            for (int unsigned p = 0; p < np; p++) begin
                if (valid[p] && we[p] && !bad[p]) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (be[4*p+b]) mm[d][wi[p]][8*b +: 8] = wdata[32*p+8*b +: 8];
                    end
                    if (be[4*p +: 4] == 4'hF) kn[d][wi[p]] = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input int unsigned np, input exp_t x,
                       input logic [3:0] v, input logic [3:0] e, input logic [127:0] d);
        check($sformatf("%s.valid", tag), {28'b0, v}, {28'b0, x.v});
        for (int unsigned p = 0; p < np; p++) begin
            if (x.v[p] || x.strict) begin
                check($sformatf("%s.p%0d.err", tag, p), {31'b0, e[p]}, {31'b0, x.e[p]});
                if (x.k[p] || x.strict)
                    check($sformatf("%s.p%0d.rdata", tag, p), d[32*p +: 32], x.d[32*p +: 32]);
            end
        end
    endtask

    task automatic tick(input string tag);
        exp_t ea, eb, pa, pb;
        model(0, 3, 4'b0011, {1'b0, a_valid}, {1'b0, a_we}, {4'b0, a_be},
              {32'b0, a_addr}, {32'b0, a_wdata}, ea);
        model(1, 2, 4'b0010, {2'b0, b_valid}, {2'b0, b_we}, {8'b0, b_be},
              {64'b0, b_addr}, {64'b0, b_wdata}, eb);
        if (!rst_n) begin
            foreach (qa[i]) qa[i] = ea;
            foreach (qb[i]) qb[i] = eb;
        end
        qa.push_back(ea);
        qb.push_back(eb);
        @(negedge clk);
        pa = qa.pop_front();
        pb = qb.pop_front();
        cmp({tag, ".A"}, 3, pa, {1'b0, a_rv}, {1'b0, a_re}, {32'b0, a_rd});
        cmp({tag, ".B"}, 2, pb, {2'b0, b_rv}, {2'b0, b_re}, {64'b0, b_rd});
    endtask

    task automatic idle();
        a_valid = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_valid = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic put_a(input int unsigned p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        a_valid[p] = 1'b1; a_we[p] = we; a_be[4*p +: 4] = be;
        a_addr[32*p +: 32] = addr; a_wdata[32*p +: 32] = wdata;
    endtask

    task automatic put_b(input int unsigned p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        b_valid[p] = 1'b1; b_we[p] = we; b_be[4*p +: 4] = be;
        b_addr[32*p +: 32] = addr; b_wdata[32*p +: 32] = wdata;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(11, 31));
        return a;
    endfunction

    initial begin
        logic [5:0] burst;

        rst_n = 1'b0;
        idle();
        qb.push_back('0);
        tick("reset0");
        tick("reset1");
        check("reset.a_valid", {29'b0, a_rv}, 32'h0);
        check("reset.b_rdata", b_rd[31:0], 32'h0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 16; i++) begin
            pre[i] = (i == 3) ? 32'hDEADBEEF : (i == 4) ? 32'hAABBCCDD : $urandom;
            idle();
            put_a(0, 1'b1, 4'hF, 4 * i, pre[i]);
            put_b(1, 1'b1, 4'hF, 4 * i, pre[i]);
            tick("preload");
        end
        idle();
        tick("drain");

        // basic read, one-cycle pulse
        idle(); put_a(0, 1'b0, 4'h0, 32'h0C, 32'h0);
        tick("rd3");
        check("rd3.valid", {31'b0, a_rv[0]}, 32'h1);
        check("rd3.rdata", a_rd[31:0], 32'hDEADBEEF);
        check("rd3.err", {31'b0, a_re[0]}, 32'h0);
        idle(); tick("rd3.after");
        check("rd3.pulse_end", {29'b0, a_rv}, 32'h0);

        // byte-masked write on permitted port (LATENCY=2)
        idle(); put_b(1, 1'b1, 4'b0101, 32'h10, 32'h11223344);
        tick("wr_be");
        idle(); tick("wr_be.wait");
        check("wr_be.old", b_rd[63:32], 32'hAABBCCDD);
        check("wr_be.valid", {30'b0, b_rv}, 32'h2);
        idle(); put_b(1, 1'b0, 4'h0, 32'h10, 32'h0);
        tick("rd_be");
        idle(); tick("rd_be.wait");
        check("rd_be.merged", b_rd[63:32], 32'hAA22CC44);

        // illegal write, out-of-range read
        idle(); put_b(0, 1'b1, 4'hF, 32'h0, 32'hFFFFFFFF);
        tick("ill_wr");
        idle(); put_b(0, 1'b0, 4'h0, 32'h800, 32'h0);
        tick("oor_rd");
        check("ill_wr.err", {31'b0, b_re[0]}, 32'h1);
        check("ill_wr.rdata", b_rd[31:0], 32'h0);
        idle(); put_b(0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick("rd0");
        check("oor_rd.err", {31'b0, b_re[0]}, 32'h1);
        check("oor_rd.rdata", b_rd[31:0], 32'h0);
        idle(); tick("rd0.wait");
        check("ill_wr.unchanged", b_rd[31:0], pre[0]);

        // same-word collision: lanes resolved by highest port, reader sees old word
        idle();
        put_a(0, 1'b1, 4'hF, 32'h14, 32'h11111111);
        put_a(1, 1'b1, 4'b0011, 32'h14, 32'h22222222);
        put_a(2, 1'b0, 4'h0, 32'h14, 32'h0);
        tick("collide");
        check("collide.p2_old", a_rd[95:64], pre[5]);
        idle(); put_a(2, 1'b0, 4'h0, 32'h14, 32'h0);
        tick("collide.rd");
        check("collide.merged", a_rd[95:64], 32'h11112222);
        check("collide.backdoor", dut_a.readWord(32'h14), 32'h11112222);

        // LATENCY=2 back-to-back burst
        burst = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            idle();
            if (i < 4) put_b(0, 1'b0, 4'h0, 4 * i, 32'h0);
            tick("burst");
            burst[i] = b_rv[0];
        end
        check("burst.pulses", {26'b0, burst}, 32'h1E);

        // reset mid-operation
        idle(); put_a(0, 1'b0, 4'h0, 32'h0C, 32'h0); put_b(0, 1'b0, 4'h0, 32'h0C, 32'h0);
        tick("pre_rst");
        idle(); rst_n = 1'b0;
        put_a(1, 1'b1, 4'hF, 32'h0C, 32'h0BADF00D); put_b(1, 1'b1, 4'hF, 32'h0C, 32'h0BADF00D);
        tick("in_rst");
        check("in_rst.b_valid", {30'b0, b_rv}, 32'h0);
        check("in_rst.a_rdata", a_rd[31:0], 32'h0);
        idle(); tick("in_rst2");
        rst_n = 1'b1;
        idle(); put_a(0, 1'b0, 4'h0, 32'h0C, 32'h0); put_b(0, 1'b0, 4'h0, 32'h0C, 32'h0);
        tick("post_rst");
        check("post_rst.a_kept", a_rd[31:0], 32'hDEADBEEF);
        idle(); tick("post_rst.wait");
        check("post_rst.b_kept", b_rd[31:0], 32'hDEADBEEF);

        // randomized traffic on both instances
        for (int unsigned n = 0; n < 300; n++) begin
            idle();
            for (int unsigned p = 0; p < 3; p++)
                if ($urandom_range(0, 3) != 0)
                    put_a(p, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
            for (int unsigned p = 0; p < 2; p++)
                if ($urandom_range(0, 3) != 0)
                    put_b(p, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
            tick("rand");
        end
        idle();
        tick("final0");
        tick("final1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mp_ram.md
# mp_ram

Parametrised multi-port word memory: the next-generation replacement for the team's dual-port instruction ROM. It serves N independent request channels (fetch, load/store, debug), each with a read or byte-masked write and a one-cycle response pulse. Latency is selectable (1 or 2 cycles), and out-of-range requests are flagged. It sits between the core's fetch/LSU/debug masters and on-chip storage, and is initialised from a hex image.

## Interface
- NUM_PORTS, 2: number of request channels (1..4).
- SIZE_BYTES, 2048: capacity, power of two, ≥ 8.
- LATENCY, 1: request-to-response cycles, 1 or 2.
- WRITE_MASK, {NUM_PORTS{1'b0}}: bit p = 1 lets port p write; writes on other ports are dropped and flagged.
- INIT_FILE_BIN, "": $readmemh image; empty = no init.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_PORTS  per-port request strobe.
- req_we_i  in  NUM_PORTS  1 = write, 0 = read.
- req_be_i  in  4*NUM_PORTS  byte enables; port p at [4p+3:4p].
- req_addr_i  in  `RISCV_ADDR_WIDTH*NUM_PORTS  byte address per port.
- req_wdata_i  in  `RISCV_WORD_WIDTH*NUM_PORTS  write data per port.
- rsp_valid_o  out  NUM_PORTS  one-cycle response pulse per accepted request.
- rsp_rdata_o  out  `RISCV_WORD_WIDTH*NUM_PORTS  read data (old contents on writes).
- rsp_err_o  out  NUM_PORTS  qualifies rsp_valid_o: out-of-range or illegal write.

## Operation
- Word index = addr[clog2(SIZE_BYTES/4)+1:2]; addr[1:0] ignored.
- Every request is accepted in its cycle; there is no backpressure and no stall.
- Error: any address bit above the index field set, or a write on a port with WRITE_MASK[p] = 0. An errored request does not modify memory, returns rdata 0, and sets err = 1.
- Read: returns mem[index] as sampled at the request edge.
- Write: for each b with be[b] = 1, mem[index][8b+7:8b] <= wdata byte. be = 0 is a legal no-op write. rdata returns the pre-write word.
- Same-cycle writes to the same word from several ports: resolved per byte lane, and the highest-numbered port wins each lane.
- Same-cycle read and write to the same word from different ports: the reader gets the old data.
- Memory contents are not affected by reset. Only control and output state is reset.

## Timing
- LATENCY = 1: request at edge k gives rsp_valid/rdata/err at edge k+1, held exactly one cycle.
- LATENCY = 2: an additional output register stage, so the response lands at k+2. Back-to-back requests each cycle give back-to-back pulses.
- Outputs are registered. No combinational path from req_* to rsp_*.
- Reset values: rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, pipeline valids = 0.
- Reset asserted mid-operation: in-flight responses are discarded. No rsp_valid pulse appears in the cycle after reset is sampled low. Writes presented in a cycle where rst_n = 0 are ignored.
- rdata and err hold their last value between pulses. Consumers qualify them with rsp_valid_o.

## Structure
- Constants belong in a shared `mem_defines.v`, `include`d alongside riscv_defines.v: MEM_BE_WIDTH = 4 and the LATENCY encodings.
- One sub-module, `mp_ram_rsp_stage`: per-port valid/rdata/err register, reset to zero. The top instantiates it once per port for LATENCY = 1 and twice (chained) for LATENCY = 2.
- The storage array and write-lane resolution stay in the top.
- Under VERILATOR, provide public readWord/writeWord accessors by byte address, for bench preload and check.

## Test plan
- Preload word 3 = 0xDEADBEEF. Port 0 reads addr 0x0C with LATENCY = 1 -> rsp_valid_o[0] = 1 at the next edge only, rdata = 0xDEADBEEF, err = 0.
- Port 1 writes (WRITE_MASK = 2'b10) addr 0x10, be = 4'b0101, wdata = 0x11223344 over an old 0xAABBCCDD -> rdata = 0xAABBCCDD. A subsequent read returns 0xAA22CC44.
- Port 0 writes with WRITE_MASK[0] = 0 -> err = 1, rdata = 0, memory unchanged. Port 0 reads addr 0x800 (SIZE_BYTES = 2048) -> err = 1, rdata = 0.
- Ports 0 and 1 both write word 5 in the same cycle (0x11111111 with be 4'b1111; 0x22222222 with be 4'b0011) -> word 5 = 0x11112222. A port-2 read of word 5 in the same cycle returns the old value.
- LATENCY = 2, requests on 4 consecutive cycles -> 4 consecutive rsp_valid pulses starting 2 edges after the first request, data in order.
- Assert rst_n low one cycle after a request -> no rsp_valid pulse, all outputs 0. After release, a read returns the preserved memory contents.
